// File: rtl/display_capture.sv
// display_capture: passive monitor for the 8-digit multiplexed 7-segment bus.
// Samples each scanned digit once its lines have been stable, decodes the
// glyph back to a nibble plus dot, and publishes a 16-bit value when all
// four right-hand digits have been seen. Also raises sticky protocol flags
// and a stale level when frames stop arriving.
module display_capture #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned TO_W   = 20
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  digit,
  input  logic [7:0]  segment,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        frame_valid,
  output logic        changed,
  output logic        bad_pattern,
  output logic        multi_err,
  output logic        upper_err,
  output logic        stale
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  localparam logic [3:0] CNT_MAX = 4'(SETTLE);
  localparam logic [3:0] CNT_HIT = 4'(SETTLE - 1);

  state_t          state, state_nx;
  logic [7:0]      dig_q, seg_q, dig_p, seg_p;
  logic [3:0]      cnt, cnt_nx;
  logic [3:0]      seen;
  logic [3:0][3:0] slot_nib;
  logic [3:0]      slot_dot;
  logic [TO_W-1:0] tcnt;

  logic       dig_chg, seg_chg, sample;
  logic [7:0] low;
  logic       lo_sel, up_sel, many;
  logic [1:0] idx;
  logic [3:0] dec_nib;
  logic       dec_ok;
  logic       complete;

  // Active-high a..g (a = MSB) to hex nibble; bit 4 flags a legal glyph.
  function automatic logic [4:0] decode7(input logic [6:0] act);
    case (act)
      7'h7E: decode7 = 5'h10;
      7'h30: decode7 = 5'h11;
      7'h6D: decode7 = 5'h12;
      7'h79: decode7 = 5'h13;
      7'h33: decode7 = 5'h14;
      7'h5B: decode7 = 5'h15;
      7'h5F: decode7 = 5'h16;
      7'h70: decode7 = 5'h17;
      7'h7F: decode7 = 5'h18;
      7'h7B: decode7 = 5'h19;
      7'h77: decode7 = 5'h1A;
      7'h1F: decode7 = 5'h1B;
      7'h4E: decode7 = 5'h1C;
      7'h3D: decode7 = 5'h1D;
      7'h4F: decode7 = 5'h1E;
      7'h47: decode7 = 5'h1F;
      default: decode7 = 5'h00;
    endcase
  endfunction

  // Input sync stage plus previous-cycle copies for change detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dig_q <= '1;
      seg_q <= '1;
      dig_p <= '1;
      seg_p <= '1;
    end else begin
      dig_q <= digit;
      seg_q <= segment;
      dig_p <= dig_q;
      seg_p <= seg_q;
    end
  end

  // Stability counter and FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      state <= S_IDLE;
    end else begin
      cnt   <= cnt_nx;
      state <= state_nx;
    end
  end

  // Next-state logic; the sample strobe fires on the cycle the count reaches SETTLE.
  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    dig_chg  = (dig_q != dig_p);
    seg_chg  = (seg_q != seg_p);
    if (dig_chg || seg_chg)  cnt_nx = '0;
    else if (cnt == CNT_MAX) cnt_nx = cnt;
    else                     cnt_nx = cnt + 4'd1;
    case (state)
      S_IDLE: begin
        if (dig_q != 8'hFF) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (dig_q == 8'hFF) begin
          state_nx = S_IDLE;
        end else if (!dig_chg && !seg_chg && cnt == CNT_HIT) begin
          state_nx = S_HELD;
          sample   = 1'b1;
        end
      end
      S_HELD: begin
        if (dig_chg) state_nx = (dig_q == 8'hFF) ? S_IDLE : S_SETTLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Classify the selected digit lines and decode the held segment pattern.
  always_comb begin
    low    = ~dig_q;
    lo_sel = (low[7:4] == 4'h0) && $onehot(low[3:0]);
    up_sel = (low[3:0] == 4'h0) && $onehot(low[7:4]);
    many   = ($countones(low) > 1);
    idx    = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (low[i]) idx = 2'(i);
    end
    {dec_ok, dec_nib} = decode7(~seg_q[7:1]);
    complete = (seen == 4'hF);
  end

  // Capture slots, frame publication, sticky flags and frame timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seen        <= '0;
      slot_nib    <= '0;
      slot_dot    <= '0;
      value       <= '0;
      dots        <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      bad_pattern <= 1'b0;
      multi_err   <= 1'b0;
      upper_err   <= 1'b0;
      tcnt        <= '0;
    end else begin
      // Completion clears the mask first so a same-cycle sample lands in the new frame.
      if (sample && lo_sel) begin
        slot_nib[idx] <= dec_nib;
        slot_dot[idx] <= ~seg_q[0];
        seen          <= (complete ? 4'h0 : seen) | (4'h1 << idx);
        if (!dec_ok) bad_pattern <= 1'b1;
      end else if (complete) begin
        seen <= '0;
      end
      if (sample && up_sel && (seg_q[7:1] != 7'h7F)) upper_err <= 1'b1;
      if (sample && many) multi_err <= 1'b1;
      frame_valid <= complete;
      changed     <= complete && ({slot_nib, slot_dot} != {value, dots});
      if (complete) begin
        value <= slot_nib;
        dots  <= slot_dot;
        tcnt  <= '0;
      end else if (tcnt != '1) begin
        tcnt <= tcnt + TO_W'(1);
      end
    end
  end

  assign stale = (tcnt == '1);

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: randomized hold-by-hold stimulus against a
// transaction-level model of the capture rules and frame timing.
module tb_display_capture;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TO_W   = 6;
  localparam int unsigned TO_MAX = 63;

  logic        clock = 1'b0;
  logic        resetn;
  logic [7:0]  digit, segment;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        frame_valid, changed, bad_pattern, multi_err, upper_err, stale;

  display_capture #(.SETTLE(SETTLE), .TO_W(TO_W)) dut (
    .clock(clock), .resetn(resetn), .digit(digit), .segment(segment),
    .value(value), .dots(dots), .frame_valid(frame_valid), .changed(changed),
    .bad_pattern(bad_pattern), .multi_err(multi_err), .upper_err(upper_err),
    .stale(stale)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dot, m_seen, m_dots;
  logic [15:0] m_value;
  bit          m_bad, m_multi, m_upper;
  int unsigned ref_cyc;
  logic [7:0]  prev_dig;
  bit          prev_long;

  typedef struct {
    int unsigned edge_t;
    logic [15:0] v;
    logic [3:0]  d;
    logic        ch;
  } frame_t;
  frame_t exp_q[$];

  function automatic int find_glyph(input logic [6:0] a);
    for (int i = 0; i < 16; i++) if (glyph[i] == a) return i;
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_seen = 0; m_dot = 0; m_dots = 0; m_value = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 0;
    m_bad = 0; m_multi = 0; m_upper = 0;
    prev_dig = 8'hFF; prev_long = 1;
  endtask

  // One sample taken from a stable hold starting at edge0.
  task automatic model_sample(input logic [7:0] d, input logic [7:0] s, input int unsigned edge0);
    logic [7:0] low;
    logic [6:0] act;
    int n, g, k;
    frame_t fr;
    low = ~d;
    act = ~s[7:1];
    n = $countones(low);
    if (n >= 2) m_multi = 1;
    else if (n == 1 && low[7:4] != 0) begin
      if (act != 0) m_upper = 1;
    end else if (n == 1) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (low[i]) k = i;
      g = find_glyph(act);
      if (g < 0) begin m_bad = 1; m_nib[k] = 0; end
      else m_nib[k] = 4'(g);
      m_dot[k]  = ~s[0];
      m_seen[k] = 1;
      if (m_seen == 4'hF) begin
        fr.v = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        fr.d = m_dot;
        fr.ch = ({fr.v, fr.d} != {m_value, m_dots});
        fr.edge_t = edge0 + SETTLE + 2;
        m_value = fr.v; m_dots = fr.d;
        exp_q.push_back(fr);
        m_seen = 0;
      end
    end
  endtask

  // Drive one digit/segment pair for L cycles; called just after a posedge.
  task automatic hold(input logic [7:0] d, input logic [7:0] s, input int unsigned L);
    int unsigned edge0;
    edge0 = cyc + 1;
    digit = d; segment = s;
    if (L >= SETTLE + 1 && d != 8'hFF && !(d == prev_dig && prev_long))
      model_sample(d, s, edge0);
    prev_dig = d;
    prev_long = (L >= SETTLE + 1);
    repeat (L) @(posedge clock);
    #1;
    check_val("bad_pattern", bad_pattern, m_bad);
    check_val("multi_err", multi_err, m_multi);
    check_val("upper_err", upper_err, m_upper);
  endtask

  task automatic scan(input logic [7:0] s2);
    hold(8'hFE, 8'h71, 16);
    hold(8'hFD, 8'h03, 16);
    hold(8'hFB, s2,    16);
    hold(8'hF7, 8'h11, 16);
  endtask

  task automatic rand_hold();
    logic [7:0] d, s;
    logic [6:0] b;
    int unsigned kind, n, L;
    do begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(0, 3);
      s = 8'($urandom);
      if (kind <= 5) begin
        d = ~(8'h01 << n);
        s = ~{glyph[$urandom_range(0, 15)], 1'($urandom)};
      end else if (kind == 6) begin
        d = ~(8'h01 << n);
        do b = 7'($urandom); while (find_glyph(b) >= 0);
        s = ~{b, 1'($urandom)};
      end else if (kind == 7) begin
        d = ~(8'h10 << n);
      end else if (kind == 8) begin
        do d = 8'($urandom); while ($countones(~d) < 2);
      end else begin
        d = 8'hFF;
      end
    end while (d == prev_dig && !prev_long);
    if ($urandom_range(0, 4) == 0) L = $urandom_range(1, SETTLE);
    else L = $urandom_range(SETTLE + 3, SETTLE + 12);
    hold(d, s, L);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_value"}, value, 0);
    check_val({tag, "_dots"}, dots, 0);
    check_val({tag, "_frame_valid"}, frame_valid, 0);
    check_val({tag, "_changed"}, changed, 0);
    check_val({tag, "_bad"}, bad_pattern, 0);
    check_val({tag, "_multi"}, multi_err, 0);
    check_val({tag, "_upper"}, upper_err, 0);
    check_val({tag, "_stale"}, stale, 0);
  endtask

  // Cycle-level monitor: frame pulses at their predicted edge, stale window.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (exp_q.size() > 0 && exp_q[0].edge_t < cyc) begin
        check_val("frame_missed", 0, 1);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].edge_t == cyc) begin
        check_val("frame_valid", frame_valid, 1);
        check_val("value", value, exp_q[0].v);
        check_val("dots", dots, exp_q[0].d);
        check_val("changed", changed, exp_q[0].ch);
        ref_cyc = cyc;
        void'(exp_q.pop_front());
      end else begin
        check_val("frame_valid_idle", frame_valid, 0);
        check_val("changed_idle", changed, 0);
      end
      check_val("stale", stale, (cyc - ref_cyc) >= TO_MAX);
    end
  end

  initial begin
    resetn = 1'b0; digit = 8'hFF; segment = 8'hFF;
    model_reset();
    #13;
    check_zero_outputs("reset");
    #10;
    ref_cyc = cyc;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Steady scan, then dot on digit 2
    repeat (3) scan(8'h9F);
    repeat (2) scan(8'h9E);
    // Glitch on digit 1 leaves the frame incomplete until a clean hold
    hold(8'hFE, 8'h71, 16);
    hold(8'hFD, 8'h03, SETTLE - 1);
    hold(8'hFB, 8'h9F, 16);
    hold(8'hF7, 8'h11, 16);
    hold(8'hFD, 8'h03, 16);
    // Segment-only change while held is ignored
    hold(8'hFE, 8'h71, 12);
    hold(8'hFE, 8'h03, 12);
    scan(8'h9F);
    // Faults
    hold(8'hFC, 8'h71, 8);
    hold(8'hEF, 8'hFE, 8);
    hold(8'hDF, 8'h9F, 8);
    hold(8'hFE, 8'h0F, 16);
    hold(8'hFD, 8'h03, 16);
    hold(8'hFB, 8'h9F, 16);
    hold(8'hF7, 8'h11, 16);

    repeat (250) rand_hold();

    // Asynchronous reset mid-scan, off the clock edge
    hold(8'hFE, 8'h71, 16);
    hold(8'hFD, 8'h03, 16);
    #3 resetn = 1'b0; digit = 8'hFF;
    #1 check_zero_outputs("async_reset");
    model_reset();
    #27;
    ref_cyc = cyc;
    resetn = 1'b1;
    @(posedge clock); #1;
    hold(8'hFB, 8'h9F, 16);
    hold(8'hF7, 8'h11, 16);
    scan(8'h9E);

    // Idle long enough to go stale, then resume
    hold(8'hFF, 8'hFF, 80);
    check_val("stale_idle", stale, 1);
    scan(8'h9F);

    repeat (150) rand_hold();
    hold(8'hFF, 8'hFF, 4);
    check_val("frames_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
